cache_ctrl: RTL and testbench

- Sequences the 2-way data cache and the external SRAM for the MEM stage of the ARM pipeline.
- Read hits complete in the request cycle. Read misses fetch a 64-bit line from SRAM, fill the cache, then return the word.
- Stores are write-through: the cache line is invalidated and the SRAM is written.
- Drives `ready` low to freeze the pipeline while SRAM is busy.

---
 rtl/cache_ctrl_pkg.sv | 9 +
 rtl/cache_addr_map.sv | 13 +
 rtl/cache_ctrl.sv | 96 +++++++++
 tb/tb_cache_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared FSM encoding, memory base and cache field widths
package cache_ctrl_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam int BASE_ADDR = 1024;
  localparam int TAG_W = 10;
  localparam int INDEX_W = 6;
endpackage

// File: rtl/cache_addr_map.sv
// cache_addr_map: byte address to cache/SRAM word address (i_addr in, o_word out)
module cache_addr_map
  import cache_ctrl_pkg::*;
#(
  parameter int BASE_ADDR    = cache_ctrl_pkg::BASE_ADDR,
  parameter int ADDR_W       = 32,
  parameter int CACHE_ADDR_W = TAG_W + INDEX_W + 1
) (
  input  logic [ADDR_W-1:0]       i_addr,
  output logic [CACHE_ADDR_W-1:0] o_word
);
  assign o_word = CACHE_ADDR_W'((i_addr - ADDR_W'(BASE_ADDR)) >> 2);
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: MEM-stage sequencer for the 2-way data cache and SRAM.
// Pipeline side: mem_r_en/mem_w_en/mem_addr/mem_wdata in, mem_rdata/ready out.
// Cache side: cache_address/wdata/r_en/w_en/is_str out, cache_rdata/hit in.
// SRAM side: sram_address/wdata/r_en/w_en out, sram_rdata/ready in.
// Stats: saturating hit_count/miss_count for loads.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int BASE_ADDR    = cache_ctrl_pkg::BASE_ADDR,
  parameter int ADDR_W       = 32,
  parameter int CACHE_ADDR_W = TAG_W + INDEX_W + 1,
  parameter int SRAM_ADDR_W  = 17,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [31:0]             mem_wdata,
  output logic [31:0]             mem_rdata,
  output logic                    ready,
  output logic [CACHE_ADDR_W-1:0] cache_address,
  output logic [63:0]             cache_wdata,
  output logic                    cache_r_en,
  output logic                    cache_w_en,
  output logic                    cache_is_str,
  input  logic [31:0]             cache_rdata,
  input  logic                    cache_hit,
  output logic [SRAM_ADDR_W-1:0]  sram_address,
  output logic [31:0]             sram_wdata,
  output logic                    sram_r_en,
  output logic                    sram_w_en,
  input  logic [63:0]             sram_rdata,
  input  logic                    sram_ready,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);
  logic [1:0]              r_state;
  logic [CACHE_ADDR_W-1:0] r_addr;
  logic [31:0]             r_wdata;
  logic [CNT_W-1:0]        r_hit;
  logic [CNT_W-1:0]        r_miss;
  logic [CACHE_ADDR_W-1:0] w_word;
  logic                    w_idle;
  logic                    w_load;
  logic                    w_store;
  cache_addr_map #(
    .BASE_ADDR(BASE_ADDR),
    .ADDR_W(ADDR_W),
    .CACHE_ADDR_W(CACHE_ADDR_W)
  ) u_map (
    .i_addr(mem_addr),
    .o_word(w_word)
  );
  // a simultaneous load+store is handled as a store; rst masks all requests
  assign w_idle  = r_state == IDLE;
  assign w_store = w_idle & ~rst & mem_w_en;
  assign w_load  = w_idle & ~rst & mem_r_en & ~mem_w_en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
    end else begin
      if (w_store) begin
        r_state <= WRITE;
        r_addr  <= w_word;
        r_wdata <= mem_wdata;
      end else if (w_load & ~cache_hit) begin
        r_state <= FILL;
        r_addr  <= w_word;
      end else if (~w_idle & sram_ready) begin
        r_state <= IDLE;
      end
      if (w_load & cache_hit & ~&r_hit) r_hit <= r_hit + CNT_W'(1);
      if (w_load & ~cache_hit & ~&r_miss) r_miss <= r_miss + CNT_W'(1);
    end
  end
  assign cache_address = w_idle ? w_word : r_addr;
  assign cache_r_en    = w_load;
  assign cache_is_str  = w_store;
  assign cache_w_en    = (r_state == FILL) & sram_ready;
  assign cache_wdata   = sram_rdata;
  assign sram_r_en     = r_state == FILL;
  assign sram_w_en     = r_state == WRITE;
  // fills fetch the whole 64-bit line, so the word offset is cleared
  assign sram_address  = SRAM_ADDR_W'(sram_r_en ? {r_addr[CACHE_ADDR_W-1:1], 1'b0} : r_addr);
  assign sram_wdata    = r_wdata;
  assign ready         = w_idle ? ~(mem_w_en | (mem_r_en & ~cache_hit)) : sram_ready;
  assign mem_rdata     = sram_r_en ? (r_addr[0] ? sram_rdata[63:32] : sram_rdata[31:0]) : cache_rdata;
  assign hit_count     = r_hit;
  assign miss_count    = r_miss;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: table-driven and scoreboard bench for cache_ctrl with a behavioural cache
module tb_cache_ctrl;
  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ready;
  logic [16:0] cache_address;
  logic [63:0] cache_wdata;
  logic        cache_r_en;
  logic        cache_w_en;
  logic        cache_is_str;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic [16:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ready(ready),
    .cache_address(cache_address), .cache_wdata(cache_wdata), .cache_r_en(cache_r_en),
    .cache_w_en(cache_w_en), .cache_is_str(cache_is_str), .cache_rdata(cache_rdata),
    .cache_hit(cache_hit),
    .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_r_en(sram_r_en),
    .sram_w_en(sram_w_en), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          c_valid [256];
  logic [63:0] c_data  [256];
  logic [7:0]  c_idx;
  assign c_idx       = cache_address[8:1];
  assign cache_hit   = c_valid[c_idx];
  assign cache_rdata = cache_address[0] ? c_data[c_idx][63:32] : c_data[c_idx][31:0];
  always @(posedge clk) begin
    if (cache_w_en) begin
      c_valid[c_idx] <= 1'b1;
      c_data[c_idx]  <= cache_wdata;
    end
    if (cache_is_str) c_valid[c_idx] <= 1'b0;
  end

  int n_chk = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  logic [31:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'd1024) >> 2;
    return d[16:0];
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [63:0] line, input int lat, input logic hit);
    logic [16:0] w;
    logic [16:0] ln;
    w = word_of(a);
    ln = {w[16:1], 1'b0};
    sb.push_back(w[0] ? line[63:32] : line[31:0]);
    @(negedge clk);
    mem_r_en = 1'b1; mem_w_en = 1'b0; mem_addr = a;
    #1;
    chk("req_cache_r_en", cache_r_en, 1);
    chk("req_cache_addr", cache_address, w);
    chk("req_ready", ready, hit);
    if (hit) begin
      exp_hit++;
      chk("hit_rdata", mem_rdata, sb.pop_front());
    end else begin
      exp_miss++;
      repeat (lat - 1) begin
        @(negedge clk); #1;
        chk("fill_sram_r_en", sram_r_en, 1);
        chk("fill_sram_addr", sram_address, ln);
        chk("fill_ready", ready, 0);
        chk("fill_early_w_en", cache_w_en, 0);
      end
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = line;
      #1;
      chk("fill_sram_addr_done", sram_address, ln);
      chk("fill_cache_w_en", cache_w_en, 1);
      chk("fill_cache_wdata", cache_wdata, line);
      chk("fill_cache_addr", cache_address, w);
      chk("fill_ready_done", ready, 1);
      chk("fill_rdata", mem_rdata, sb.pop_front());
    end
    @(negedge clk);
    mem_r_en = 1'b0; sram_ready = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat, input logic with_r);
    logic [16:0] w;
    w = word_of(a);
    @(negedge clk);
    mem_w_en = 1'b1; mem_r_en = with_r; mem_addr = a; mem_wdata = d;
    #1;
    chk("st_is_str", cache_is_str, 1);
    chk("st_cache_r_en", cache_r_en, 0);
    chk("st_ready", ready, 0);
    repeat (lat - 1) begin
      @(negedge clk); #1;
      chk("st_sram_w_en", sram_w_en, 1);
      chk("st_sram_r_en", sram_r_en, 0);
      chk("st_sram_addr", sram_address, w);
      chk("st_sram_wdata", sram_wdata, d);
      chk("st_is_str_once", cache_is_str, 0);
      chk("st_busy_ready", ready, 0);
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    chk("st_done_w_en", sram_w_en, 1);
    chk("st_done_ready", ready, 1);
    chk("st_no_fill", cache_w_en, 0);
    @(negedge clk);
    mem_w_en = 1'b0; mem_r_en = 1'b0; sram_ready = 1'b0;
    #1;
    chk("st_idle_w_en", sram_w_en, 0);
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] line;
    int          lat;
    logic        hit;
  } vec_t;
  vec_t vt[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'h408, 32'h0, 64'hBBBBBBBB_AAAAAAAA, 5, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'h40C, 32'h0, 64'hBBBBBBBB_AAAAAAAA, 1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 32'h40C, 32'h12345678, 64'h0, 3, 1'b0};
    vt[3] = '{1'b0, 1'b1, 32'h40C, 32'h0, 64'h12345678_AAAAAAAA, 1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 32'h408, 32'h0, 64'h12345678_AAAAAAAA, 1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 32'h500, 32'h0, 64'h11111111_22222222, 2, 1'b0};
    vt[6] = '{1'b1, 1'b1, 32'h504, 32'hCAFEF00D, 64'h0, 2, 1'b0};
    vt[7] = '{1'b0, 1'b1, 32'h504, 32'h0, 64'hCAFEF00D_22222222, 3, 1'b0};
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = 32'h400; mem_wdata = '0;
    sram_rdata = '0; sram_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sram_r_en", sram_r_en, 0);
    chk("rst_sram_w_en", sram_w_en, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_cache_r_en", cache_r_en, 0);
    chk("rst_cache_w_en", cache_w_en, 0);
    chk("rst_is_str", cache_is_str, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    for (int i = 0; i < 8; i++) begin
      if (vt[i].w) do_store(vt[i].addr, vt[i].wdata, vt[i].lat, vt[i].r);
      else do_load(vt[i].addr, vt[i].line, vt[i].lat, vt[i].hit);
      #1;
      chk("vec_hit_count", hit_count, exp_hit);
      chk("vec_miss_count", miss_count, exp_miss);
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    chk("spur_ready", ready, 1);
    chk("spur_sram_r_en", sram_r_en, 0);
    @(negedge clk);
    sram_ready = 1'b0;
    #1;
    chk("spur_after_r_en", sram_r_en, 0);
    chk("spur_after_w_en", sram_w_en, 0);
    do_load(32'h408, 64'h12345678_AAAAAAAA, 1, 1'b1);
    @(negedge clk);
    mem_r_en = 1'b1; mem_addr = 32'h600;
    repeat (2) @(negedge clk);
    #1;
    chk("midfill_sram_r_en", sram_r_en, 1);
    rst = 1'b1;
    #1;
    chk("midfill_rst_r_en", sram_r_en, 0);
    chk("midfill_rst_w_en", cache_w_en, 0);
    mem_r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_hit = 0; exp_miss = 0;
    #1;
    chk("post_rst_r_en", sram_r_en, 0);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_hits", hit_count, 0);
    chk("post_rst_miss", miss_count, 0);
    do_load(32'h600, 64'h33333333_44444444, 2, 1'b0);
    chk("after_abort_miss", miss_count, exp_miss);
    @(negedge clk);
    mem_r_en = 1'b1; mem_addr = 32'h408;
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_near", hit_count, 16'hFFFE);
    @(negedge clk); #1;
    chk("sat_full", hit_count, 16'hFFFF);
    @(negedge clk); #1;
    chk("sat_hold", hit_count, 16'hFFFF);
    chk("sat_ready", ready, 1);
    chk("sat_miss", miss_count, exp_miss);
    mem_r_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
